// File: rtl/rst_req_gen_if.sv
// Request/status bundle between the reset-request originator and its controller.
// The master drives the requests and the slave (rst_req_gen) returns the reset line and status.
interface rst_req_gen_if;
  logic       soft_rst_req;
  logic       wdog_en;
  logic       kick;
  logic       RST_req_n;
  logic [1:0] rst_cause;
  logic       busy;

  modport master (
    output soft_rst_req, wdog_en, kick,
    input  RST_req_n, rst_cause, busy
  );

  modport slave (
    input  soft_rst_req, wdog_en, kick,
    output RST_req_n, rst_cause, busy
  );
endinterface

// File: rtl/rst_req_gen.sv
// Reset-request originator: a soft request or a watchdog timeout becomes a fixed-width RST_req_n pulse, followed by a holdoff.
// The watchdog is built only when RST_REQ_WDOG_EN is defined; otherwise only soft_rst_req triggers.
module rst_req_gen #(
  parameter int unsigned WDOG_W       = 16,
  parameter int unsigned WDOG_TIMEOUT = 50000,
  parameter int unsigned PULSE_CYC    = 16,
  parameter int unsigned HOLDOFF_CYC  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  rst_req_gen_if.slave bus
);

  localparam int unsigned PH_MAX = (PULSE_CYC > HOLDOFF_CYC) ? PULSE_CYC : HOLDOFF_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [1:0]      cause_q, cause_d;
  logic            rst_req_n_q, rst_req_n_d;
  logic            busy_q, busy_d;
  logic            armed;
  logic            wdog_fire;
  logic            trig;

  // The last holdoff cycle behaves as idle so a held request re-fires without a gap.
  assign armed = (state_q == ST_IDLE) ||
                 ((state_q == ST_HOLDOFF) && (phase_q == PH_W'(HOLDOFF_CYC - 1)));
  assign trig  = armed && (bus.soft_rst_req || wdog_fire);

`ifdef RST_REQ_WDOG_EN
  localparam logic [WDOG_W-1:0] WCNT_TOP = WDOG_W'(WDOG_TIMEOUT - 1);

  logic [WDOG_W-1:0] wcnt_q, wcnt_d;

  // Kick in the timeout cycle wins over the fire.
  assign wdog_fire = armed && bus.wdog_en && !bus.kick && (wcnt_q == WCNT_TOP);

  // Counter runs only while idle and enabled; held at zero while busy, saturates at the top.
  always_comb begin
    wcnt_d = '0;
    if ((state_q == ST_IDLE) && bus.wdog_en && !bus.kick && !trig) begin
      wcnt_d = (wcnt_q == WCNT_TOP) ? wcnt_q : wcnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`else
  logic unused_wdog;

  assign wdog_fire   = 1'b0;
  assign unused_wdog = ^{bus.wdog_en, bus.kick};
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      cause_q     <= 2'b00;
      rst_req_n_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cause_q     <= cause_d;
      rst_req_n_q <= rst_req_n_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and shared phase counter.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_ASSERT;
          phase_d = '0;
        end
      end
      ST_ASSERT: begin
        if (phase_q == PH_W'(PULSE_CYC - 1)) begin
          state_d = ST_HOLDOFF;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (trig) begin
          state_d = ST_ASSERT;
          phase_d = '0;
        end else if (phase_q == PH_W'(HOLDOFF_CYC - 1)) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Output values to be registered at the next edge.
  always_comb begin
    rst_req_n_d = (state_d != ST_ASSERT);
    busy_d      = (state_d != ST_IDLE);
    cause_d     = cause_q;
    if (trig) begin
      cause_d = {wdog_fire, bus.soft_rst_req};
    end
  end

  assign bus.RST_req_n = rst_req_n_q;
  assign bus.rst_cause = cause_q;
  assign bus.busy      = busy_q;

endmodule
